// File: rtl/sd_block_reader.sv
// sd_block_reader
// SPI-mode SD block-read sequencer. Issues CMD17 (single block) or CMD18 +
// CMD12 (multi block) through a byte-level SPI engine. Received data bytes
// are written into a slotted block buffer, and the consumer frees the slots.
module sd_block_reader #(
   parameter int BLOCK_BYTES   = 512,
   parameter int BUF_SLOTS     = 2,
   parameter int BUF_AW        = 10,
   parameter int CNT_W         = 16,
   parameter int BLOCK_ADDR    = 1,
   parameter int NCR_MAX       = 8,
   parameter int TOKEN_TIMEOUT = 4096,
   localparam int SLOT_W       = (BUF_SLOTS > 1) ? $clog2(BUF_SLOTS) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req,
   input  logic [31:0]       req_addr,
   input  logic [CNT_W-1:0]  req_count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code,
   output logic              xfer_start,
   output logic [7:0]        xfer_tx,
   input  logic              xfer_done,
   input  logic [7:0]        xfer_rx,
   output logic              cs_n,
   output logic              buf_we,
   output logic [BUF_AW-1:0] buf_waddr,
   output logic [7:0]        buf_wdata,
   output logic              blk_valid,
   output logic [SLOT_W-1:0] blk_slot,
   input  logic              blk_release
);

   localparam int IDX_W  = (BLOCK_BYTES > 8) ? $clog2(BLOCK_BYTES) : 3;
   localparam int POLL_N = (TOKEN_TIMEOUT > NCR_MAX) ? TOKEN_TIMEOUT : NCR_MAX;
   localparam int POLL_W = $clog2(POLL_N + 1);
   localparam int USED_W = $clog2(BUF_SLOTS + 1);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_BYTES - 1);
   localparam logic [IDX_W-1:0]  CMD_LAST  = IDX_W'(5);
   localparam logic [POLL_W-1:0] NCR_LAST  = POLL_W'(NCR_MAX - 1);
   localparam logic [POLL_W-1:0] TOK_LAST  = POLL_W'(TOKEN_TIMEOUT - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BUF_SLOTS - 1);
   localparam logic [USED_W-1:0] SLOTS_N   = USED_W'(BUF_SLOTS);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_PRE      = 4'd1;
   localparam logic [3:0] S_CMD      = 4'd2;
   localparam logic [3:0] S_R1       = 4'd3;
   localparam logic [3:0] S_WAITSLOT = 4'd4;
   localparam logic [3:0] S_TOKEN    = 4'd5;
   localparam logic [3:0] S_DATA     = 4'd6;
   localparam logic [3:0] S_CRC      = 4'd7;
   localparam logic [3:0] S_NEXT     = 4'd8;
   localparam logic [3:0] S_STOP     = 4'd9;
   localparam logic [3:0] S_STUFF    = 4'd10;
   localparam logic [3:0] S_STOP_R1  = 4'd11;
   localparam logic [3:0] S_BUSY     = 4'd12;
   localparam logic [3:0] S_FIN      = 4'd13;

   logic [3:0]        state_reg;
   logic              pend_reg;
   logic              xfer_start_reg;
   logic [7:0]        xfer_tx_reg;
   logic              cs_n_reg;
   logic              done_reg;
   logic              err_reg;
   logic [2:0]        err_code_reg;
   logic              blk_valid_reg;
   logic [SLOT_W-1:0] blk_slot_reg;
   logic [SLOT_W-1:0] wr_slot_reg;
   logic [USED_W-1:0] used_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [POLL_W-1:0] poll_reg;
   logic [31:0]       addr_reg;
   logic [CNT_W-1:0]  remain_reg;
   logic              multi_reg;

   logic [31:0]       cmd_arg;
   logic [7:0]        arg_byte [4];
   logic [7:0]        tx_byte;

   // SDSC cards take a byte address; the product is deliberately truncated to 32 bits
   assign cmd_arg = (BLOCK_ADDR != 0) ? addr_reg : addr_reg * 32'(BLOCK_BYTES);

   for (genvar gi = 0; gi < 4; gi++) begin : g_arg
      assign arg_byte[gi] = cmd_arg[31 - 8*gi -: 8];
   end

   // Byte to transmit for the exchange about to be issued; polls send 0xFF
   always_comb begin
      tx_byte = 8'hFF;
      case (state_reg)
         S_CMD: begin
            case (idx_reg)
               IDX_W'(0): tx_byte = multi_reg ? 8'h52 : 8'h51;
               IDX_W'(1): tx_byte = arg_byte[0];
               IDX_W'(2): tx_byte = arg_byte[1];
               IDX_W'(3): tx_byte = arg_byte[2];
               IDX_W'(4): tx_byte = arg_byte[3];
               default:   tx_byte = 8'hFF;
            endcase
         end
         S_STOP: begin
            if (idx_reg == IDX_W'(0))
               tx_byte = 8'h4C;
            else if (idx_reg == CMD_LAST)
               tx_byte = 8'hFF;
            else
               tx_byte = 8'h00;
         end
         default: tx_byte = 8'hFF;
      endcase
   end

   // Sequencer: one outstanding byte exchange at a time, the reply is handled on xfer_done
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= S_IDLE;
         pend_reg       <= 1'b0;
         xfer_start_reg <= 1'b0;
         xfer_tx_reg    <= 8'hFF;
         cs_n_reg       <= 1'b1;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         err_code_reg   <= 3'd0;
         blk_valid_reg  <= 1'b0;
         blk_slot_reg   <= '0;
         wr_slot_reg    <= '0;
         idx_reg        <= '0;
         poll_reg       <= '0;
         addr_reg       <= '0;
         remain_reg     <= '0;
         multi_reg      <= 1'b0;
      end else begin
         xfer_start_reg <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         blk_valid_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (req) begin
                  if (req_count == '0) begin
                     err_reg      <= 1'b1;
                     err_code_reg <= 3'd5;
                  end else begin
                     addr_reg     <= req_addr;
                     remain_reg   <= req_count;
                     multi_reg    <= (req_count != CNT_W'(1));
                     err_code_reg <= 3'd0;
                     cs_n_reg     <= 1'b0;
                     state_reg    <= S_PRE;
                  end
               end
            end
            S_WAITSLOT: begin
               if (used_reg < SLOTS_N) begin
                  state_reg <= S_TOKEN;
                  poll_reg  <= '0;
               end
            end
            S_NEXT: begin
               idx_reg <= '0;
               if (remain_reg != '0)
                  state_reg <= S_WAITSLOT;
               else if (multi_reg)
                  state_reg <= S_STOP;
               else
                  state_reg <= S_FIN;
            end
            default: begin
               if (!pend_reg) begin
                  pend_reg       <= 1'b1;
                  xfer_start_reg <= 1'b1;
                  xfer_tx_reg    <= tx_byte;
               end else if (xfer_done) begin
                  pend_reg <= 1'b0;
                  case (state_reg)
                     S_PRE: begin
                        state_reg <= S_CMD;
                        idx_reg   <= '0;
                     end
                     S_CMD: begin
                        if (idx_reg == CMD_LAST) begin
                           state_reg <= S_R1;
                           poll_reg  <= '0;
                        end else begin
                           idx_reg <= idx_reg + IDX_W'(1);
                        end
                     end
                     S_R1, S_STOP_R1: begin
                        if (!xfer_rx[7]) begin
                           if (xfer_rx == 8'h00) begin
                              state_reg <= (state_reg == S_R1) ? S_WAITSLOT : S_BUSY;
                              poll_reg  <= '0;
                           end else begin
                              state_reg <= S_IDLE; cs_n_reg <= 1'b1; err_reg <= 1'b1; err_code_reg <= 3'd2;
                           end
                        end else if (poll_reg == NCR_LAST) begin
                           state_reg <= S_IDLE; cs_n_reg <= 1'b1; err_reg <= 1'b1; err_code_reg <= 3'd1;
                        end else begin
                           poll_reg <= poll_reg + POLL_W'(1);
                        end
                     end
                     S_TOKEN: begin
                        if (xfer_rx == 8'hFE) begin
                           state_reg <= S_DATA;
                           idx_reg   <= '0;
                        end else if (xfer_rx[7:4] == 4'h0) begin
                           state_reg <= S_IDLE; cs_n_reg <= 1'b1; err_reg <= 1'b1; err_code_reg <= 3'd4;
                        end else if (poll_reg == TOK_LAST) begin
                           state_reg <= S_IDLE; cs_n_reg <= 1'b1; err_reg <= 1'b1; err_code_reg <= 3'd3;
                        end else begin
                           poll_reg <= poll_reg + POLL_W'(1);
                        end
                     end
                     S_DATA: begin
                        if (idx_reg == LAST_IDX) begin
                           state_reg <= S_CRC;
                           idx_reg   <= '0;
                        end else begin
                           idx_reg <= idx_reg + IDX_W'(1);
                        end
                     end
                     S_CRC: begin
                        if (idx_reg == IDX_W'(1)) begin
                           blk_valid_reg <= 1'b1;
                           blk_slot_reg  <= wr_slot_reg;
                           wr_slot_reg   <= (wr_slot_reg == SLOT_LAST) ? '0 : wr_slot_reg + SLOT_W'(1);
                           remain_reg    <= remain_reg - CNT_W'(1);
                           state_reg     <= S_NEXT;
                        end else begin
                           idx_reg <= idx_reg + IDX_W'(1);
                        end
                     end
                     S_STOP: begin
                        if (idx_reg == CMD_LAST)
                           state_reg <= S_STUFF;
                        else
                           idx_reg <= idx_reg + IDX_W'(1);
                     end
                     S_STUFF: begin
                        state_reg <= S_STOP_R1;
                        poll_reg  <= '0;
                     end
                     S_BUSY: begin
                        if (xfer_rx != 8'h00) begin
                           state_reg <= S_FIN;
                        end else if (poll_reg == TOK_LAST) begin
                           state_reg <= S_IDLE; cs_n_reg <= 1'b1; err_reg <= 1'b1; err_code_reg <= 3'd3;
                        end else begin
                           poll_reg <= poll_reg + POLL_W'(1);
                        end
                     end
                     S_FIN: begin
                        state_reg <= S_IDLE;
                        cs_n_reg  <= 1'b1;
                        done_reg  <= 1'b1;
                     end
                     default: state_reg <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   // Used-slot count: a completed block and a release in the same cycle cancel out
   always_ff @(posedge CLK) begin
      if (RST)
         used_reg <= '0;
      else if (blk_valid_reg && !blk_release)
         used_reg <= used_reg + USED_W'(1);
      else if (!blk_valid_reg && blk_release && (used_reg != '0))
         used_reg <= used_reg - USED_W'(1);
   end

   assign busy       = (state_reg != S_IDLE);
   assign done       = done_reg;
   assign err        = err_reg;
   assign err_code   = err_code_reg;
   assign xfer_start = xfer_start_reg;
   assign xfer_tx    = xfer_tx_reg;
   assign cs_n       = cs_n_reg;
   assign buf_we     = (state_reg == S_DATA) && pend_reg && xfer_done;
   assign buf_waddr  = BUF_AW'(wr_slot_reg) * BUF_AW'(BLOCK_BYTES) + BUF_AW'(idx_reg);
   assign buf_wdata  = xfer_rx;
   assign blk_valid  = blk_valid_reg;
   assign blk_slot   = blk_slot_reg;

endmodule
